// File: rtl/bcd_to_bin32.sv
// Sequential packed-BCD to binary converter using reverse double-dabble.
// One shift/correct iteration per clock, start/done handshake, registered outputs.
module bcd_to_bin32 #(
  parameter int DIGITS = 8,
  localparam int W = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bcd_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] bin_out
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

  state_t           state, state_nxt;
  logic [2*W-1:0]   sreg, sreg_nxt;
  logic [2*W-1:0]   shifted, corrected;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             busy_nxt, done_nxt, err_nxt;
  logic [W-1:0]     bin_nxt;
  logic             bad_digit;
  logic             last_iter;

  assign last_iter = (cnt == CW'(W - 1));

  // State and all output registers; reset aborts any conversion silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      bin_out <= bin_nxt;
    end
  end

  // Shift right, then pull each upper digit that reached 8+ back down by 3.
  always_comb begin
    shifted   = sreg >> 1;
    corrected = shifted;
    for (int d = 0; d < DIGITS; d++) begin
      if (shifted[W+4*d +: 4] >= 4'd8)
        corrected[W+4*d +: 4] = shifted[W+4*d +: 4] - 4'd3;
    end
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9)
        bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = bad_digit ? FIN : CONV;
      CONV: if (last_iter) state_nxt = FIN;
      // An error entry arrives with done still low, so FIN lingers one extra cycle.
      FIN:  if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sreg_nxt = sreg;
    cnt_nxt  = cnt;
    busy_nxt = busy;
    done_nxt = 1'b0;
    err_nxt  = err;
    bin_nxt  = bin_out;
    case (state)
      IDLE: begin
        if (start) begin
          busy_nxt = 1'b1;
          err_nxt  = bad_digit;
          cnt_nxt  = '0;
          if (bad_digit) begin
            sreg_nxt = '0;
            bin_nxt  = '0;
          end else begin
            sreg_nxt = {bcd_in, {W{1'b0}}};
          end
        end
      end
      CONV: begin
        sreg_nxt = corrected;
        cnt_nxt  = cnt + 1'b1;
        if (last_iter) begin
          done_nxt = 1'b1;
          bin_nxt  = corrected[W-1:0];
        end
      end
      FIN: begin
        if (done) begin
          busy_nxt = 1'b0;
        end else begin
          done_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bcd_to_bin32.sv
// Self-checking bench for bcd_to_bin32: a table of directed conversions
// plus hand-written sequences for ignored starts, reset abort and back-to-back.
module tb_bcd_to_bin32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] bcd_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] bin_out;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic [31:0] bcd;
    logic [31:0] bin;
    logic        bad;
  } vec_t;

  vec_t vecs[10];

  bcd_to_bin32 #(.DIGITS(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Waits up to a bounded number of edges for done; returns edges waited (-1 on timeout).
  task automatic wait_done(input int limit, output int waited, output int busy_low);
    waited   = -1;
    busy_low = 0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (!busy) busy_low++;
      if (done) begin
        waited = i;
        break;
      end
    end
    if (waited < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_done: no done within %0d cycles", limit);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] bcd, input logic [31:0] exp_bin, input logic bad);
    int waited, busy_low;
    start  = 1'b1;
    bcd_in = bcd;
    tick();
    start  = 1'b0;
    bcd_in = 32'h5A5A_5A5A;
    check_output("busy_after_start", {31'd0, busy}, 32'd1);
    check_output("err_at_accept", {31'd0, err}, {31'd0, bad});
    wait_done(40, waited, busy_low);
    if (waited >= 0) begin
      check_output("latency", waited, bad ? 32'd1 : 32'd32);
      check_output("busy_during_conv", busy_low, 32'd0);
      check_output("bin_out", bin_out, exp_bin);
      check_output("err_with_done", {31'd0, err}, {31'd0, bad});
      tick();
      check_output("done_one_cycle", {31'd0, done}, 32'd0);
      check_output("busy_after_fin", {31'd0, busy}, 32'd0);
      check_output("bin_out_held", bin_out, exp_bin);
      check_output("err_held", {31'd0, err}, {31'd0, bad});
    end
  endtask

  initial begin
    int waited, busy_low, pulses, t1, t2;

    vecs[0] = '{32'h1234_5678, 32'h00BC_614E, 1'b0};
    vecs[1] = '{32'h9999_9999, 32'h05F5_E0FF, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'h0000_000A, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_0009, 32'h0000_0009, 1'b0};
    vecs[5] = '{32'h8765_4321, 32'h0539_7FB1, 1'b0};
    vecs[6] = '{32'hA000_0000, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'h0000_0100, 32'h0000_0064, 1'b0};
    vecs[8] = '{32'h0000_0F00, 32'h0000_0000, 1'b1};
    vecs[9] = '{32'h0000_0080, 32'h0000_0050, 1'b0};

    reset  = 1'b0;
    start  = 1'b0;
    bcd_in = 32'h0;
    #1;
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_done", {31'd0, done}, 32'd0);
    check_output("reset_err", {31'd0, err}, 32'd0);
    check_output("reset_bin", bin_out, 32'd0);
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();

    $display("[TB] table-driven conversions");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].bcd, vecs[i].bin, vecs[i].bad);
      tick();
    end

    $display("[TB] start pulses while busy are ignored");
    pulses = 0;
    start  = 1'b1;
    bcd_in = 32'h0000_0042;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    start  = 1'b1;
    bcd_in = 32'h0000_0099;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) tick();
    if (done) pulses++;
    check_output("ignored_bin", bin_out, 32'h0000_002A);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("fin_start_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    check_output("ignored_pulses", pulses, 32'd1);
    check_output("ignored_bin_held", bin_out, 32'h0000_002A);

    $display("[TB] reset mid-conversion");
    start  = 1'b1;
    bcd_in = 32'h8765_4321;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_output("abort_busy", {31'd0, busy}, 32'd0);
    check_output("abort_done", {31'd0, done}, 32'd0);
    check_output("abort_bin", bin_out, 32'd0);
    tick();
    tick();
    @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    check_output("abort_no_done", pulses, 32'd0);
    apply_stimulus(32'h0000_0100, 32'h0000_0064, 1'b0);
    tick();

    $display("[TB] back-to-back conversions");
    start  = 1'b1;
    bcd_in = 32'h0000_0001;
    tick();
    start  = 1'b0;
    wait_done(40, waited, busy_low);
    t1 = cycle;
    check_output("b2b_first_bin", bin_out, 32'h0000_0001);
    tick();
    start  = 1'b1;
    bcd_in = 32'h0000_0010;
    tick();
    start  = 1'b0;
    check_output("b2b_accept", {31'd0, busy}, 32'd1);
    wait_done(40, waited, busy_low);
    t2 = cycle;
    check_output("b2b_second_bin", bin_out, 32'h0000_000A);
    // FIN edge, first IDLE edge accepting start, then 32 iterations.
    check_output("b2b_gap", t2 - t1, 32'd34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
